fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Multicycle sequencing controller for the instruction-fetch datapath. Decides when the instruction memory/PC unit advances and which `pcmux` source it uses: sequential, JAL, conditional branch or JALR. Decodes the fetched RV32I opcode and drives the register-file write, data-memory strobes and writeback select. Waits on the data-memory ready handshake, and halts on illegal or system opcodes.

## Interface
- `MEM_TIMEOUT`, 15: max cycles spent in MEM waiting for `dmem_ready` before trapping (1..255).
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `idata`  in  32  instruction word from the fetch unit.
- `fetch_tog`  in  1  fetch-done toggle (the fetch unit's `new`); flips once per completed fetch.
- `br_taken`  in  1  branch-condition result from the ALU, valid in EXEC.
- `dmem_ready`  in  1  data-memory access complete.
- `fetch_en`  out  1  one-cycle strobe; the fetch unit advances only while high.
- `pcmux`  out  2  0=JALR (rv1+imm), 1=JAL (pc+imm), 2=branch (uses `br_in`), 3=sequential.
- `br_in`  out  1  registered branch decision presented with `pcmux`=2.
- `reg_we`  out  1  register-file write enable, high only in WB.
- `mem_re`, `mem_we`  out  1 each  data-memory read/write strobes, held through MEM.
- `alu_src_imm`  out  1  ALU operand B = immediate.
- `wb_sel`  out  2  0=ALU, 1=memory, 2=pc (link), 3=immediate (LUI).
- `halted`  out  1  controller stopped.
- `trap`  out  1  halt was caused by an illegal opcode or a memory timeout.
- `state`  out  3  current state, debug.

## Operation
- States are RESET(0), FETCH(1), FWAIT(2), DECODE(3), EXEC(4), MEM(5), WB(6), HALT(7).
- RESET → FETCH on the first clock after `rst_n` deasserts.
- FETCH:
  - Pulse `fetch_en`, drive the stored `pcmux`/`br_in`.
  - Latch the current `fetch_tog` into `tog_q`.
  - Go to FWAIT.
- FWAIT: stay until `fetch_tog != tog_q`, then capture `idata` into `ir` and go to DECODE.
- DECODE: decode `ir[6:0]`.
  - Legal opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
  - SYSTEM (1110011) → HALT with `trap`=0.
  - Any other opcode → HALT with `trap`=1.
- EXEC computes the next `pcmux`:
  - JALR → 0.
  - JAL → 1.
  - BRANCH → 2, with `br_in` ← `br_taken`.
  - Everything else → 3.
- EXEC next state:
  - LOAD/STORE → MEM.
  - BRANCH → FETCH (no writeback).
  - Others → WB.
- MEM:
  - Hold `mem_re` (LOAD) or `mem_we` (STORE).
  - On `dmem_ready`: STORE → FETCH, LOAD → WB.
  - Counter reaching `MEM_TIMEOUT` without ready → HALT with `trap`=1.
  - If `dmem_ready` arrives in the same cycle the counter reaches `MEM_TIMEOUT`, ready wins.
- WB: `reg_we`=1 for exactly one cycle, then → FETCH.
- HALT: all strobes 0, `halted`=1; held until reset.
- `alu_src_imm`=1 for LOAD, STORE, OP-IMM, JALR, AUIPC. `wb_sel` is decoded in DECODE and held until the next DECODE.

## Timing
- All outputs are registered.
- Reset values:
  - `state`=0, `pcmux`=3, `br_in`=0.
  - All strobes 0, `wb_sel`=0, `alu_src_imm`=0.
  - `halted`=0, `trap`=0, `ir`=0.
- Minimum instruction latencies (FWAIT taking 1 cycle):
  - Branch: 4 cycles.
  - ALU/jump: 5 cycles.
  - Store: 5 cycles.
  - Load: 6 cycles.
  - Each extra FWAIT or MEM wait cycle adds 1.
- The `pcmux` decided in EXEC takes effect at the next FETCH strobe. It stays stable from EXEC to that FETCH.
- Asserting `rst_n` mid-instruction immediately clears all strobes and the state; no partial writeback occurs.
- The MEM timeout counter clears on entry to MEM.

## Configuration
- `FETCH_CTRL_PERF_EN` defined:
  - Adds outputs `cyc_cnt[31:0]` (increments every cycle not in RESET/HALT) and `ret_cnt[31:0]` (increments on each transition into FETCH from EXEC, MEM or WB).
  - Both counters wrap modulo 2^32 and reset to 0.
- Macro undefined: neither port nor counter logic exists.

## Test plan
- Reset release with `idata`=0x00000013 (ADDI), `fetch_tog` toggling 1 cycle after each strobe → state sequence 1,2,3,4,6,1; `reg_we` high 1 cycle; `pcmux`=3.
- BEQ (0x00000063) with `br_taken`=1 → at the next FETCH, `pcmux`=2, `br_in`=1, `reg_we` never asserted.
- JAL 0x0080006F, then JALR 0x000080E7 → `pcmux`=1 then 0 at consecutive FETCH strobes; `wb_sel`=2 in both WB cycles.
- LW with `dmem_ready` after 3 cycles → `mem_re` high for 4 cycles, then WB with `wb_sel`=1. SW with ready never asserted → `halted`=1, `trap`=1 after 15 MEM cycles.
- `idata`=0xFFFFFFFF → HALT with `trap`=1. ECALL 0x00000073 → HALT with `trap`=0. `rst_n` pulsed low during MEM → outputs return to reset values asynchronously.
- With `FETCH_CTRL_PERF_EN` defined, 10 ADDI instructions → `ret_cnt`=10, `cyc_cnt`=50.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Multicycle sequencing controller for the RV32I fetch datapath: steps the fetch unit, picks
// the pcmux source and drives writeback/data-memory strobes. Optional FETCH_CTRL_PERF_EN adds perf counters.
module fetch_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] idata,
  input  logic        fetch_tog,
  input  logic        br_taken,
  input  logic        dmem_ready,
  output logic        fetch_en,
  output logic [1:0]  pcmux,
  output logic        br_in,
  output logic        reg_we,
  output logic        mem_re,
  output logic        mem_we,
  output logic        alu_src_imm,
  output logic [1:0]  wb_sel,
  output logic        halted,
  output logic        trap,
  output logic [2:0]  state
`ifdef FETCH_CTRL_PERF_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_RESET  = 3'd0,
    S_FETCH  = 3'd1,
    S_FWAIT  = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4,
    S_MEM    = 3'd5,
    S_WB     = 3'd6,
    S_HALT   = 3'd7
  } state_t;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [1:0] PC_JALR = 2'd0;
  localparam logic [1:0] PC_JAL  = 2'd1;
  localparam logic [1:0] PC_BR   = 2'd2;
  localparam logic [1:0] PC_SEQ  = 2'd3;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_MEM = 2'd1;
  localparam logic [1:0] WB_PC  = 2'd2;
  localparam logic [1:0] WB_IMM = 2'd3;

  localparam logic [7:0] LP_TIMEOUT = 8'(MEM_TIMEOUT);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_ir;
  logic        r_tog_q;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_inc;
  logic        w_tog_seen;
  logic        w_trap_cause;
  logic        w_unused_ir;

  logic [6:0]  w_opc;
  logic        w_is_legal;
  logic        w_is_system;
  logic        w_is_load;
  logic        w_is_store;
  logic        w_is_branch;
  logic        w_is_jal;
  logic        w_is_jalr;
  logic [1:0]  w_dec_wb_sel;
  logic        w_dec_imm;

  logic        r_fetch_en,    w_fetch_en_nxt;
  logic [1:0]  r_pcmux,       w_pcmux_nxt;
  logic        r_br_in,       w_br_in_nxt;
  logic        r_reg_we,      w_reg_we_nxt;
  logic        r_mem_re,      w_mem_re_nxt;
  logic        r_mem_we,      w_mem_we_nxt;
  logic        r_alu_src_imm, w_alu_src_imm_nxt;
  logic [1:0]  r_wb_sel,      w_wb_sel_nxt;
  logic        r_halted,      w_halted_nxt;
  logic        r_trap,        w_trap_nxt;

  assign w_opc       = r_ir[6:0];
  assign w_unused_ir = ^r_ir[31:7];
  assign w_tog_seen  = (fetch_tog != r_tog_q);
  assign w_cnt_inc   = r_cnt + 8'd1;

  // Opcode class decode; ir is stable from FWAIT capture until the next fetch completes.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path infers a latch.
    w_is_legal   = 1'b1;
    w_is_system  = 1'b0;
    w_is_load    = 1'b0;
    w_is_store   = 1'b0;
    w_is_branch  = 1'b0;
    w_is_jal     = 1'b0;
    w_is_jalr    = 1'b0;
    w_dec_wb_sel = WB_ALU;
    w_dec_imm    = 1'b0;
    case (w_opc)
      OPC_LUI:    w_dec_wb_sel = WB_IMM;
      OPC_AUIPC:  w_dec_imm = 1'b1;
      OPC_JAL: begin
        w_is_jal     = 1'b1;
        w_dec_wb_sel = WB_PC;
      end
      OPC_JALR: begin
        w_is_jalr    = 1'b1;
        w_dec_wb_sel = WB_PC;
        w_dec_imm    = 1'b1;
      end
      OPC_BRANCH: w_is_branch = 1'b1;
      OPC_LOAD: begin
        w_is_load    = 1'b1;
        w_dec_wb_sel = WB_MEM;
        w_dec_imm    = 1'b1;
      end
      OPC_STORE: begin
        w_is_store = 1'b1;
        w_dec_imm  = 1'b1;
      end
      OPC_OPIMM:  w_dec_imm = 1'b1;
      OPC_OP:     ;
      OPC_SYSTEM: begin
        w_is_legal  = 1'b0;
        w_is_system = 1'b1;
      end
      default:    w_is_legal = 1'b0;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_RESET;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic
  always_comb begin
    w_state_nxt  = r_state;
    w_trap_cause = 1'b0;
    case (r_state)
      S_RESET:  w_state_nxt = S_FETCH;
      S_FETCH:  w_state_nxt = S_FWAIT;
      S_FWAIT:  if (w_tog_seen) w_state_nxt = S_DECODE;
      S_DECODE: begin
        if (w_is_system) begin
          w_state_nxt = S_HALT;
        end else if (!w_is_legal) begin
          w_state_nxt  = S_HALT;
          w_trap_cause = 1'b1;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        if (w_is_load || w_is_store) w_state_nxt = S_MEM;
        else if (w_is_branch)        w_state_nxt = S_FETCH;
        else                         w_state_nxt = S_WB;
      end
      S_MEM: begin
        // ready is tested first so it wins over a simultaneous timeout
        if (dmem_ready) begin
          w_state_nxt = w_is_store ? S_FETCH : S_WB;
        end else if (w_cnt_inc == LP_TIMEOUT) begin
          w_state_nxt  = S_HALT;
          w_trap_cause = 1'b1;
        end
      end
      S_WB:     w_state_nxt = S_FETCH;
      S_HALT:   w_state_nxt = S_HALT;
      default:  w_state_nxt = S_RESET;
    endcase
  end

  // FSM output logic: values for the state being entered, registered below
  always_comb begin
    w_fetch_en_nxt    = (w_state_nxt == S_FETCH);
    w_reg_we_nxt      = (w_state_nxt == S_WB);
    w_mem_re_nxt      = (w_state_nxt == S_MEM) && w_is_load;
    w_mem_we_nxt      = (w_state_nxt == S_MEM) && w_is_store;
    w_halted_nxt      = (w_state_nxt == S_HALT);
    w_trap_nxt        = (r_state == S_HALT) ? r_trap : w_trap_cause;
    w_pcmux_nxt       = r_pcmux;
    w_br_in_nxt       = r_br_in;
    w_wb_sel_nxt      = r_wb_sel;
    w_alu_src_imm_nxt = r_alu_src_imm;
    if (r_state == S_EXEC) begin
      w_br_in_nxt = 1'b0;
      if (w_is_jalr)        w_pcmux_nxt = PC_JALR;
      else if (w_is_jal)    w_pcmux_nxt = PC_JAL;
      else if (w_is_branch) begin
        w_pcmux_nxt = PC_BR;
        w_br_in_nxt = br_taken;
      end else              w_pcmux_nxt = PC_SEQ;
    end
    if (r_state == S_DECODE) begin
      w_wb_sel_nxt      = w_dec_wb_sel;
      w_alu_src_imm_nxt = w_dec_imm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fetch_en    <= 1'b0;
      r_pcmux       <= PC_SEQ;
      r_br_in       <= 1'b0;
      r_reg_we      <= 1'b0;
      r_mem_re      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_alu_src_imm <= 1'b0;
      r_wb_sel      <= WB_ALU;
      r_halted      <= 1'b0;
      r_trap        <= 1'b0;
    end else begin
      r_fetch_en    <= w_fetch_en_nxt;
      r_pcmux       <= w_pcmux_nxt;
      r_br_in       <= w_br_in_nxt;
      r_reg_we      <= w_reg_we_nxt;
      r_mem_re      <= w_mem_re_nxt;
      r_mem_we      <= w_mem_we_nxt;
      r_alu_src_imm <= w_alu_src_imm_nxt;
      r_wb_sel      <= w_wb_sel_nxt;
      r_halted      <= w_halted_nxt;
      r_trap        <= w_trap_nxt;
    end
  end

  // Fetch handshake, instruction register and MEM timeout counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tog_q <= 1'b0;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      if (r_state == S_FETCH) r_tog_q <= fetch_tog;
      if (r_state == S_FWAIT && w_tog_seen) r_ir <= idata;
      r_cnt <= (r_state == S_MEM) ? w_cnt_inc : 8'd0;
    end
  end

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] r_cyc_cnt;
  logic [31:0] r_ret_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cyc_cnt <= '0;
      r_ret_cnt <= '0;
    end else begin
      if (r_state != S_RESET && r_state != S_HALT) r_cyc_cnt <= r_cyc_cnt + 32'd1;
      if (w_state_nxt == S_FETCH && (r_state inside {S_EXEC, S_MEM, S_WB}))
        r_ret_cnt <= r_ret_cnt + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc_cnt;
  assign ret_cnt = r_ret_cnt;
`endif

  assign fetch_en    = r_fetch_en;
  assign pcmux       = r_pcmux;
  assign br_in       = r_br_in;
  assign reg_we      = r_reg_we;
  assign mem_re      = r_mem_re;
  assign mem_we      = r_mem_we;
  assign alu_src_imm = r_alu_src_imm;
  assign wb_sel      = r_wb_sel;
  assign halted      = r_halted;
  assign trap        = r_trap;
  assign state       = r_state;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed self-checking bench for fetch_ctrl; the fetch unit is emulated by toggling
// fetch_tog one cycle after each fetch_en strobe.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] idata;
  logic        fetch_tog;
  logic        br_taken;
  logic        dmem_ready;
  logic        fetch_en;
  logic [1:0]  pcmux;
  logic        br_in;
  logic        reg_we;
  logic        mem_re;
  logic        mem_we;
  logic        alu_src_imm;
  logic [1:0]  wb_sel;
  logic        halted;
  logic        trap;
  logic [2:0]  state;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] cyc_cnt;
  logic [31:0] ret_cnt;
`endif

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] I_ADDI  = 32'h0000_0013;
  localparam logic [31:0] I_BEQ   = 32'h0000_0063;
  localparam logic [31:0] I_JAL   = 32'h0080_006F;
  localparam logic [31:0] I_JALR  = 32'h0000_80E7;
  localparam logic [31:0] I_LW    = 32'h0000_2003;
  localparam logic [31:0] I_SW    = 32'h0000_2023;
  localparam logic [31:0] I_ILL   = 32'hFFFF_FFFF;
  localparam logic [31:0] I_ECALL = 32'h0000_0073;

  fetch_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .idata       (idata),
    .fetch_tog   (fetch_tog),
    .br_taken    (br_taken),
    .dmem_ready  (dmem_ready),
    .fetch_en    (fetch_en),
    .pcmux       (pcmux),
    .br_in       (br_in),
    .reg_we      (reg_we),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .alu_src_imm (alu_src_imm),
    .wb_sel      (wb_sel),
    .halted      (halted),
    .trap        (trap),
    .state       (state)
`ifdef FETCH_CTRL_PERF_EN
    ,
    .cyc_cnt     (cyc_cnt),
    .ret_cnt     (ret_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock; the fetch unit answers a strobe seen this cycle by toggling just after the edge.
  task automatic tick();
    logic fe;
    fe = fetch_en;
    @(posedge clk);
    #1;
    if (fe) fetch_tog = ~fetch_tog;
  endtask

  task automatic step(input logic [2:0] exp_st, input string tag);
    tick();
    check(tag, 32'(state), 32'(exp_st));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n      = 1'b0;
    idata      = I_ADDI;
    fetch_tog  = 1'b0;
    br_taken   = 1'b0;
    dmem_ready = 1'b0;
    do_reset();

    check("rst_state",   32'(state),       32'd0);
    check("rst_pcmux",   32'(pcmux),       32'd3);
    check("rst_br_in",   32'(br_in),       32'd0);
    check("rst_fetch",   32'(fetch_en),    32'd0);
    check("rst_reg_we",  32'(reg_we),      32'd0);
    check("rst_mem_re",  32'(mem_re),      32'd0);
    check("rst_mem_we",  32'(mem_we),      32'd0);
    check("rst_wb_sel",  32'(wb_sel),      32'd0);
    check("rst_imm",     32'(alu_src_imm), 32'd0);
    check("rst_halted",  32'(halted),      32'd0);
    check("rst_trap",    32'(trap),        32'd0);

    // ADDI: FETCH, FWAIT, DECODE, EXEC, WB, FETCH
    step(3'd1, "addi_st_fetch");
    check("addi_fetch_en", 32'(fetch_en), 32'd1);
    step(3'd2, "addi_st_fwait");
    check("addi_fetch_en_off", 32'(fetch_en), 32'd0);
    step(3'd3, "addi_st_decode");
    step(3'd4, "addi_st_exec");
    check("addi_imm", 32'(alu_src_imm), 32'd1);
    check("addi_wb_sel", 32'(wb_sel), 32'd0);
    step(3'd6, "addi_st_wb");
    check("addi_reg_we", 32'(reg_we), 32'd1);
    check("addi_pcmux", 32'(pcmux), 32'd3);
    step(3'd1, "addi_st_fetch2");
    check("addi_reg_we_off", 32'(reg_we), 32'd0);
    check("addi_fetch_en2", 32'(fetch_en), 32'd1);

    // BEQ taken: 4-cycle instruction, no writeback
    idata    = I_BEQ;
    br_taken = 1'b1;
    step(3'd2, "beq_st_fwait");
    check("beq_reg_we_a", 32'(reg_we), 32'd0);
    step(3'd3, "beq_st_decode");
    check("beq_reg_we_b", 32'(reg_we), 32'd0);
    step(3'd4, "beq_st_exec");
    check("beq_reg_we_c", 32'(reg_we), 32'd0);
    step(3'd1, "beq_st_fetch");
    check("beq_pcmux", 32'(pcmux), 32'd2);
    check("beq_br_in", 32'(br_in), 32'd1);
    check("beq_reg_we_d", 32'(reg_we), 32'd0);
    br_taken = 1'b0;

    // JAL then JALR
    idata = I_JAL;
    step(3'd2, "jal_st_fwait");
    step(3'd3, "jal_st_decode");
    step(3'd4, "jal_st_exec");
    step(3'd6, "jal_st_wb");
    check("jal_wb_sel", 32'(wb_sel), 32'd2);
    check("jal_reg_we", 32'(reg_we), 32'd1);
    step(3'd1, "jal_st_fetch");
    check("jal_pcmux", 32'(pcmux), 32'd1);
    check("jal_fetch_en", 32'(fetch_en), 32'd1);
    idata = I_JALR;
    step(3'd2, "jalr_st_fwait");
    step(3'd3, "jalr_st_decode");
    step(3'd4, "jalr_st_exec");
    check("jalr_imm", 32'(alu_src_imm), 32'd1);
    check("jalr_pcmux_held", 32'(pcmux), 32'd1);
    step(3'd6, "jalr_st_wb");
    check("jalr_wb_sel", 32'(wb_sel), 32'd2);
    step(3'd1, "jalr_st_fetch");
    check("jalr_pcmux", 32'(pcmux), 32'd0);

    // LW with ready during the 4th MEM cycle: mem_re high 4 cycles
    idata = I_LW;
    step(3'd2, "lw_st_fwait");
    step(3'd3, "lw_st_decode");
    step(3'd4, "lw_st_exec");
    step(3'd5, "lw_st_mem1");
    check("lw_mem_re1", 32'(mem_re), 32'd1);
    check("lw_mem_we1", 32'(mem_we), 32'd0);
    for (int i = 2; i <= 4; i++) begin
      step(3'd5, "lw_st_memn");
      check("lw_mem_ren", 32'(mem_re), 32'd1);
    end
    dmem_ready = 1'b1;
    step(3'd6, "lw_st_wb");
    dmem_ready = 1'b0;
    check("lw_reg_we", 32'(reg_we), 32'd1);
    check("lw_wb_sel", 32'(wb_sel), 32'd1);
    check("lw_mem_re_off", 32'(mem_re), 32'd0);
    step(3'd1, "lw_st_fetch");

    // SW with no ready: trap after 15 MEM cycles
    idata = I_SW;
    step(3'd2, "sw_st_fwait");
    step(3'd3, "sw_st_decode");
    step(3'd4, "sw_st_exec");
    step(3'd5, "sw_st_mem1");
    check("sw_mem_we1", 32'(mem_we), 32'd1);
    check("sw_mem_re1", 32'(mem_re), 32'd0);
    for (int i = 2; i <= 15; i++) begin
      step(3'd5, "sw_st_memn");
      check("sw_mem_wen", 32'(mem_we), 32'd1);
    end
    step(3'd7, "sw_st_halt");
    check("sw_halted", 32'(halted), 32'd1);
    check("sw_trap", 32'(trap), 32'd1);
    check("sw_mem_we_off", 32'(mem_we), 32'd0);
    step(3'd7, "sw_st_halt_held");
    check("sw_fetch_en_off", 32'(fetch_en), 32'd0);

    // Illegal opcode
    do_reset();
    check("ill_rst_halted", 32'(halted), 32'd0);
    check("ill_rst_trap", 32'(trap), 32'd0);
    idata = I_ILL;
    step(3'd1, "ill_st_fetch");
    step(3'd2, "ill_st_fwait");
    step(3'd3, "ill_st_decode");
    step(3'd7, "ill_st_halt");
    check("ill_halted", 32'(halted), 32'd1);
    check("ill_trap", 32'(trap), 32'd1);

    // ECALL halts without trap
    do_reset();
    idata = I_ECALL;
    step(3'd1, "ecall_st_fetch");
    step(3'd2, "ecall_st_fwait");
    step(3'd3, "ecall_st_decode");
    step(3'd7, "ecall_st_halt");
    check("ecall_halted", 32'(halted), 32'd1);
    check("ecall_trap", 32'(trap), 32'd0);

    // Asynchronous reset in the middle of a load
    do_reset();
    idata = I_LW;
    step(3'd1, "arst_st_fetch");
    step(3'd2, "arst_st_fwait");
    step(3'd3, "arst_st_decode");
    step(3'd4, "arst_st_exec");
    step(3'd5, "arst_st_mem");
    check("arst_mem_re_before", 32'(mem_re), 32'd1);
    check("arst_wb_sel_before", 32'(wb_sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_state", 32'(state), 32'd0);
    check("arst_mem_re", 32'(mem_re), 32'd0);
    check("arst_reg_we", 32'(reg_we), 32'd0);
    check("arst_fetch_en", 32'(fetch_en), 32'd0);
    check("arst_wb_sel", 32'(wb_sel), 32'd0);
    check("arst_imm", 32'(alu_src_imm), 32'd0);
    check("arst_pcmux", 32'(pcmux), 32'd3);
    @(posedge clk);
    #1;
    check("arst_reg_we_held", 32'(reg_we), 32'd0);
    check("arst_state_held", 32'(state), 32'd0);
    rst_n = 1'b1;

`ifdef FETCH_CTRL_PERF_EN
    // Ten ADDI instructions at 5 cycles each
    do_reset();
    idata = I_ADDI;
    step(3'd1, "perf_st_fetch");
    for (int i = 0; i < 50; i++) tick();
    check("perf_state", 32'(state), 32'd1);
    check("perf_ret_cnt", ret_cnt, 32'd10);
    check("perf_cyc_cnt", cyc_cnt, 32'd50);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
